// File: rtl/ula_seq.sv
// Multi-cycle ALU for the execute stage: single-cycle logic/compare ops,
// iterative shift-add multiply and restoring divide, registered result.
module ula_seq #(
    parameter int WIDTH = 32,
    parameter int CW    = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CW-1:0]    controle,
    input  logic [WIDTH-1:0] DA,
    input  logic [WIDTH-1:0] DB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ULAresult,
    output logic             zero,
    output logic             negativo,
    output logic             overflow,
    output logic             divzero
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    localparam logic [CW-1:0] OP_ADC    = CW'(0);
    localparam logic [CW-1:0] OP_SUB    = CW'(1);
    localparam logic [CW-1:0] OP_E      = CW'(2);
    localparam logic [CW-1:0] OP_OU     = CW'(3);
    localparam logic [CW-1:0] OP_N      = CW'(4);
    localparam logic [CW-1:0] OP_SLEL   = CW'(5);
    localparam logic [CW-1:0] OP_SRIL   = CW'(6);
    localparam logic [CW-1:0] OP_BEQ    = CW'(7);
    localparam logic [CW-1:0] OP_BNEQ   = CW'(8);
    localparam logic [CW-1:0] OP_BLZ    = CW'(9);
    localparam logic [CW-1:0] OP_SLET   = CW'(10);
    localparam logic [CW-1:0] OP_SGRT   = CW'(11);
    localparam logic [CW-1:0] OP_MULT   = CW'(12);
    localparam logic [CW-1:0] OP_DIV    = CW'(13);
    localparam logic [CW-1:0] OP_MOD    = CW'(14);
    localparam logic [CW-1:0] OP_EXOR   = CW'(15);
    localparam logic [CW-1:0] OP_NOTAND = CW'(16);
    localparam logic [CW-1:0] OP_NOTOR  = CW'(17);
    localparam logic [CW-1:0] OP_BLT    = CW'(18);
    localparam logic [CW-1:0] OP_BGRT   = CW'(19);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] WLIM = WIDTH'(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;      // partial product high half / remainder
    logic [WIDTH-1:0] lo_q, lo_d;      // multiplier bits / dividend-quotient
    logic [WIDTH-1:0] opnd_q, opnd_d;  // multiplicand or divisor
    logic             mod_q, mod_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             ovf_q, ovf_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   adc_sum;
    logic [WIDTH-1:0] sc_res;
    logic             sc_ovf;
    logic             sc_dz;

    logic [WIDTH:0]   madd;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    logic [WIDTH:0]   dshift;
    logic             dge;
    logic [WIDTH-1:0] ddiff;
    logic [WIDTH-1:0] div_hi, div_lo;

    // Single-cycle results, evaluated from the live inputs at the start edge
    always_comb begin
        sc_res  = '0;
        sc_ovf  = 1'b0;
        sc_dz   = 1'b0;
        adc_sum = {1'b0, DA} + {1'b0, DB};
        case (controle)
            OP_ADC: begin
                if (adc_sum[WIDTH]) sc_ovf = 1'b1;
                else                sc_res = adc_sum[WIDTH-1:0];
            end
            OP_SUB:    sc_res = DA - DB;
            OP_E:      sc_res = DA & DB;
            OP_OU:     sc_res = DA | DB;
            OP_N:      sc_res = (DA == '0) ? ONE : '0;
            OP_SLEL:   sc_res = (DB < WLIM) ? (DA << DB) : '0;
            OP_SRIL:   sc_res = (DB < WLIM) ? (DA >> DB) : '0;
            OP_BEQ:    sc_res = (DA == DB) ? '0 : ONE;
            OP_BNEQ:   sc_res = (DA != DB) ? ONE : '0;
            OP_BLZ:    sc_res = DA;
            OP_SLET:   sc_res = (DA < DB) ? ONE : '0;
            OP_SGRT:   sc_res = (DA > DB) ? ONE : '0;
            OP_DIV: begin
                sc_res = '1;
                sc_dz  = (DB == '0);
            end
            OP_MOD: begin
                sc_res = DA;
                sc_dz  = (DB == '0);
            end
            OP_EXOR:   sc_res = DA ^ DB;
            OP_NOTAND: sc_res = ~(DA & DB);
            OP_NOTOR:  sc_res = ~(DA | DB);
            OP_BLT:    sc_res = (DA < DB) ? '0 : ONE;
            OP_BGRT:   sc_res = (DA > DB) ? '0 : ONE;
            default:   sc_res = '0;
        endcase
    end

    // One iteration of each sequence; hi/lo registers are shared between them
    always_comb begin
        madd   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_hi = madd[WIDTH:1];
        mul_lo = {madd[0], lo_q[WIDTH-1:1]};

        dshift = {hi_q, lo_q[WIDTH-1]};
        dge    = (dshift >= {1'b0, opnd_q});
        ddiff  = dshift[WIDTH-1:0] - opnd_q;
        div_hi = dge ? ddiff : dshift[WIDTH-1:0];
        div_lo = {lo_q[WIDTH-2:0], dge};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        mod_d   = mod_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    if (controle == OP_MULT) begin
                        state_d = ST_MUL;
                        hi_d    = '0;
                        lo_d    = DB;
                        opnd_d  = DA;
                    end else if ((controle == OP_DIV || controle == OP_MOD) && DB != '0) begin
                        state_d = ST_DIV;
                        hi_d    = '0;
                        lo_d    = DA;
                        opnd_d  = DB;
                        mod_d   = (controle == OP_MOD);
                    end else begin
                        res_d  = sc_res;
                        ovf_d  = sc_ovf;
                        dz_d   = sc_dz;
                        done_d = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                hi_d  = mul_hi;
                lo_d  = mul_lo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    dz_d    = 1'b0;
                    if (mul_hi != '0) begin
                        res_d = '0;
                        ovf_d = 1'b1;
                    end else begin
                        res_d = mul_lo;
                        ovf_d = 1'b0;
                    end
                end
            end
            ST_DIV: begin
                hi_d  = div_hi;
                lo_d  = div_lo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    dz_d    = 1'b0;
                    ovf_d   = 1'b0;
                    res_d   = mod_q ? div_hi : div_lo;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            mod_q   <= 1'b0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            mod_q   <= mod_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign ULAresult = res_q;
    assign zero      = (res_q == '0);
    assign negativo  = res_q[WIDTH-1];
    assign overflow  = ovf_q;
    assign divzero   = dz_q;

endmodule

// File: tb/tb_ula_seq.sv
// Scoreboarded random + directed bench for ula_seq: stimulus pushes expected
// completions, an independent monitor pops them on every done pulse.
module tb_ula_seq;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [4:0]    controle;
    logic [W-1:0]  DA, DB;
    logic          busy, done, zero, negativo, overflow, divzero;
    logic [W-1:0]  ULAresult;

    ula_seq #(.WIDTH(W), .CW(5)) dut (
        .clock(clock), .reset(reset), .start(start), .controle(controle),
        .DA(DA), .DB(DB), .busy(busy), .done(done), .ULAresult(ULAresult),
        .zero(zero), .negativo(negativo), .overflow(overflow), .divzero(divzero)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
        logic         dz;
        logic         multi;
        int unsigned  due;
        logic [4:0]   op;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model straight from the opcode table, using 64-bit arithmetic
    function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        longint unsigned s;
        e.res = '0; e.ovf = 1'b0; e.dz = 1'b0; e.multi = 1'b0; e.due = 0; e.op = op;
        case (op)
            0: begin
                s = longint'(a) + longint'(b);
                if (s > 64'hFFFF_FFFF) e.ovf = 1'b1; else e.res = s[31:0];
            end
            1:  e.res = a - b;
            2:  e.res = a & b;
            3:  e.res = a | b;
            4:  e.res = (a == 0) ? 1 : 0;
            5:  e.res = (b >= 32) ? 0 : a << b;
            6:  e.res = (b >= 32) ? 0 : a >> b;
            7:  e.res = (a == b) ? 0 : 1;
            8:  e.res = (a != b) ? 1 : 0;
            9:  e.res = a;
            10: e.res = (a < b) ? 1 : 0;
            11: e.res = (a > b) ? 1 : 0;
            12: begin
                s = longint'(a) * longint'(b);
                e.multi = 1'b1;
                if (s > 64'hFFFF_FFFF) e.ovf = 1'b1; else e.res = s[31:0];
            end
            13: if (b == 0) begin e.res = 32'hFFFF_FFFF; e.dz = 1'b1; end
                else begin e.res = a / b; e.multi = 1'b1; end
            14: if (b == 0) begin e.res = a; e.dz = 1'b1; end
                else begin e.res = a % b; e.multi = 1'b1; end
            15: e.res = a ^ b;
            16: e.res = ~(a & b);
            17: e.res = ~(a | b);
            18: e.res = (a < b) ? 0 : 1;
            19: e.res = (a > b) ? 0 : 1;
            default: e.res = 0;
        endcase
        return e;
    endfunction

    task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   guard = 0;
        while (busy && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (busy) chk("issue_wait_timeout", 1, 0);
        e = model(op, a, b);
        e.due = cyc + 1 + (e.multi ? W : 0);
        sb.push_back(e);
        start = 1'b1; controle = op; DA = a; DB = b;
        @(negedge clock);
        start = 1'b0;
        chk($sformatf("busy_after_start op%0d", op), {63'b0, busy}, {63'b0, e.multi});
    endtask

    function automatic logic [W-1:0] rnd_val();
        logic [W-1:0] v;
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = $urandom_range(0, 40);
            2: v = 32'hFFFF_FFFF - $urandom_range(0, 3);
            default: v = 32'h1 << $urandom_range(0, 31);
        endcase
        return v;
    endfunction

    // Monitor: checks each completion and that outputs hold between them
    exp_t         mon_e;
    logic [W-1:0] last_res = '0;
    logic         last_ovf = 1'b0;
    logic         last_dz  = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            last_res = '0; last_ovf = 1'b0; last_dz = 1'b0;
        end else if (done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk($sformatf("result op%0d", mon_e.op), ULAresult, mon_e.res);
                chk($sformatf("overflow op%0d", mon_e.op), overflow, mon_e.ovf);
                chk($sformatf("divzero op%0d", mon_e.op), divzero, mon_e.dz);
                chk($sformatf("zero op%0d", mon_e.op), zero, mon_e.res == 0);
                chk($sformatf("negativo op%0d", mon_e.op), negativo, mon_e.res[W-1]);
                chk($sformatf("latency op%0d", mon_e.op), cyc, mon_e.due);
                last_res = mon_e.res; last_ovf = mon_e.ovf; last_dz = mon_e.dz;
            end
        end else begin
            chk("hold_result", ULAresult, last_res);
            chk("hold_overflow", overflow, last_ovf);
            chk("hold_divzero", divzero, last_dz);
        end
    end

    initial begin
        int guard;
        reset = 1'b1; start = 1'b0; controle = '0; DA = '0; DB = '0;
        repeat (3) @(negedge clock);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", ULAresult, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_divzero", divzero, 0);
        chk("reset_zero", zero, 1);
        chk("reset_negativo", negativo, 0);
        reset = 1'b0;
        @(negedge clock);

        issue(0, 32'hFFFF_FFFF, 1);
        issue(1, 3, 5);
        issue(12, 32'h10000, 32'h10000);
        issue(12, 1234, 5678);
        issue(13, 100, 7);
        issue(14, 100, 7);
        issue(13, 5, 0);
        issue(0, 1, 2);
        issue(5, 1, 31);
        issue(6, 32'hDEAD_BEEF, 40);
        issue(7, 5, 5);
        issue(19, 9, 3);
        issue(25, 32'h1234, 32'h5678);
        issue(14, 9, 0);

        // start held high through a whole multiply must not be queued
        issue(12, 7, 6);
        start = 1'b1; controle = 5'd0; DA = 32'd1; DB = 32'd1;
        guard = 0;
        while (busy && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        start = 1'b0;
        chk("held_start_bounded", busy, 0);
        issue(0, 10, 20);

        // reset 10 cycles into a multiply: aborted, nothing completes
        guard = 0;
        while (busy && guard < 100) begin @(negedge clock); guard++; end
        @(negedge clock);
        start = 1'b1; controle = 5'd12; DA = 7; DB = 6;
        @(negedge clock);
        start = 1'b0;
        chk("mul_busy_before_reset", busy, 1);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_result", ULAresult, 0);
        chk("abort_zero", zero, 1);
        chk("abort_done", done, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (W + 5) @(negedge clock);

        for (int i = 0; i < 80; i++) begin
            logic [4:0] op;
            op = ($urandom_range(0, 3) == 0) ? 5'(12 + $urandom_range(0, 2)) : 5'($urandom_range(0, 31));
            issue(op, rnd_val(), (op == 12) ? 32'($urandom_range(0, 70000)) : rnd_val());
        end

        guard = 0;
        while (sb.size() > 0 && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        repeat (5) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
